slow_chain_seq: RTL

//  Sequencer/master for the byte-serial slow readout chain (slow_op/slow_snap/slow_out).

---
 rtl/slow_chain_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/slow_chain_seq.sv
// slow_chain_seq
//   Sequencer for the byte-serial slow readout chain. On a request it pulses
//   the chain snap (parallel load of min/max, tag and timestamp), then shifts
//   the chain out one byte per accepted valid/ready handshake.
//   A frame is started by a host start pulse, or by trig while auto_en is high.
//
// Optional feature macro: SLOW_SEQ_CHECKSUM_EN
//   When defined, one extra byte follows the chain bytes. It is the two's
//   complement of the mod-256 sum of the chain bytes, and it carries byte_last.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   start, auto_en,     frame requests (start pulse, or auto_en & trig)
//   trig
//   clr_overrun         clears the sticky overrun flag
//   slow_op, slow_snap  chain shift/capture enable and parallel-load strobe
//   slow_out            chain head byte, valid one cycle after slow_op
//   byte_out/valid/     downstream byte stream; byte_last marks the end of a frame
//   ready/last
//   busy                frame in progress
//   frame_cnt           count of completed frames (wraps)
//   overrun             sticky: a request arrived while busy
module slow_chain_seq #(
  parameter int CHAIN_LEN = 22,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          auto_en,
  input  logic          trig,
  input  logic          clr_overrun,
  output logic          slow_op,
  output logic          slow_snap,
  input  logic [7:0]    slow_out,
  output logic [7:0]    byte_out,
  output logic          byte_valid,
  input  logic          byte_ready,
  output logic          byte_last,
  output logic          busy,
  output logic [CW-1:0] frame_cnt,
  output logic          overrun
);

  typedef enum logic [1:0] {S_IDLE, S_SNAP, S_LOAD, S_PRESENT} state_t;

  // The last chain byte has index CHAIN_LEN-1. Later bytes in the frame are
  // not fetched from the chain.
  localparam logic [8:0] SHIFT_MAX = 9'(CHAIN_LEN - 1);
`ifdef SLOW_SEQ_CHECKSUM_EN
  localparam logic [8:0] LAST_IDX  = 9'(CHAIN_LEN);
`else
  localparam logic [8:0] LAST_IDX  = 9'(CHAIN_LEN - 1);
`endif

  state_t          state_q, state_d;
  logic [8:0]      idx_q, idx_d;
  logic [7:0]      byte_out_q, byte_out_d;
  logic            byte_valid_q, byte_valid_d;
  logic            byte_last_q, byte_last_d;
  logic [CW-1:0]   frame_cnt_q, frame_cnt_d;
  logic            overrun_q, overrun_d;
`ifdef SLOW_SEQ_CHECKSUM_EN
  logic [7:0]      sum_q, sum_d;
`endif

  logic go, hs, op_c, snap_c;

  assign go = start | (auto_en & trig);
  assign hs = byte_valid_q & byte_ready;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = byte_valid_q;
    byte_last_d  = byte_last_q;
    frame_cnt_d  = frame_cnt_q;
    op_c         = 1'b0;
    snap_c       = 1'b0;
`ifdef SLOW_SEQ_CHECKSUM_EN
    sum_d        = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (go) state_d = S_SNAP;
      end
      S_SNAP: begin
        op_c    = 1'b1;
        snap_c  = 1'b1;
        idx_d   = '0;
`ifdef SLOW_SEQ_CHECKSUM_EN
        sum_d   = '0;
`endif
        state_d = S_LOAD;
      end
      S_LOAD: begin
`ifdef SLOW_SEQ_CHECKSUM_EN
        // Past the chain, slow_out is stale; present the checksum instead.
        if (idx_q > SHIFT_MAX) byte_out_d = 8'(8'd0 - sum_q);
        else                   byte_out_d = slow_out;
        sum_d = sum_q + slow_out;
`else
        byte_out_d = slow_out;
`endif
        byte_valid_d = 1'b1;
        byte_last_d  = (idx_q == LAST_IDX);
        state_d      = S_PRESENT;
      end
      S_PRESENT: begin
        if (hs) begin
          byte_valid_d = 1'b0;
          if (byte_last_q) begin
            byte_last_d = 1'b0;
            frame_cnt_d = frame_cnt_q + CW'(1);
            state_d     = S_IDLE;
          end else begin
            // The chain advances in the handshake cycle, so its next head byte
            // is ready for capture in LOAD.
            op_c    = (idx_q < SHIFT_MAX);
            idx_d   = idx_q + 9'd1;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A request while busy is dropped and flagged. The set takes priority over the clear.
    if (go && state_q != S_IDLE) overrun_d = 1'b1;
    else if (clr_overrun)        overrun_d = 1'b0;
    else                         overrun_d = overrun_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
      frame_cnt_q  <= '0;
      overrun_q    <= 1'b0;
`ifdef SLOW_SEQ_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      byte_last_q  <= byte_last_d;
      frame_cnt_q  <= frame_cnt_d;
      overrun_q    <= overrun_d;
`ifdef SLOW_SEQ_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  // Chain strobes are combinational from the state. Gating them with rst
  // prevents a shift in the cycle that resets the sequencer.
  assign slow_op    = op_c & ~rst;
  assign slow_snap  = snap_c & ~rst;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign byte_last  = byte_last_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_cnt  = frame_cnt_q;
  assign overrun    = overrun_q;

endmodule
